// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame controller (RX_MAJORITY_EN selects 2-of-3 majority bit sampling)
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            edge_cnt,
    input  logic [3:0]            bit_cnt,
    input  logic                  finish,
    output logic                  enable,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad_q;
    logic                  smp_mid;
    logic                  bit_done;
    logic                  bit_now;
    logic                  active;
    logic [5:0]            mid;
    logic [5:0]            pt_mid;
    logic [5:0]            pt_hi;
`ifdef RX_MAJORITY_EN
    logic                  smp_lo;
    logic                  smp_hi;
    logic [5:0]            pt_lo;
`endif

    // Sample points around mid-bit; bit 0 is shifted one clock early because its period is one clock short
    always_comb begin
        active = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
        mid    = prescale >> 1;
        pt_mid = mid;
        pt_hi  = mid + 6'd1;
        if (bit_cnt == 4'd0) begin
            pt_mid = mid - 6'd1;
            pt_hi  = mid;
        end
`ifdef RX_MAJORITY_EN
        pt_lo = pt_mid - 6'd1;
        bit_now = (smp_lo & smp_mid) | (smp_lo & smp_hi) | (smp_mid & smp_hi);
`else
        bit_now = smp_mid;
`endif
    end

    // Capture line samples and flag the cycle after the last sample point as the decision cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            smp_mid  <= 1'b0;
            bit_done <= 1'b0;
`ifdef RX_MAJORITY_EN
            smp_lo   <= 1'b0;
            smp_hi   <= 1'b0;
`endif
        end else begin
            bit_done <= active && (edge_cnt == pt_hi);
            if (active && (edge_cnt == pt_mid)) smp_mid <= rx_in;
`ifdef RX_MAJORITY_EN
            if (active && (edge_cnt == pt_lo)) smp_lo <= rx_in;
            if (active && (edge_cnt == pt_hi)) smp_hi <= rx_in;
`endif
        end
    end

    // Frame FSM with registered counter enable and one-cycle result pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            enable     <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state     <= START;
                        enable    <= 1'b1;
                        shift_q   <= '0;
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ;
                        par_bad_q <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done && bit_now) begin
                        state  <= IDLE;
                        enable <= 1'b0;
                    end else if (finish && (bit_cnt == 4'd0)) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) shift_q <= {bit_now, shift_q[DATA_WIDTH-1:1]};
                    if (finish && (bit_cnt == LAST_DATA)) state <= par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (bit_done) par_bad_q <= (bit_now != (^shift_q ^ par_typ_q));
                    if (finish) state <= STOP;
                end
                STOP: begin
                    // Leave as soon as the stop bit is decided so the next start edge has margin
                    if (bit_done) begin
                        state   <= DONE;
                        enable  <= 1'b0;
                        par_err <= par_bad_q;
                        stp_err <= !bit_now;
                        if (!par_bad_q && bit_now) begin
                            data_valid <= 1'b1;
                            p_data     <= shift_q;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed frame bench with line-level receiver model
module tb_uart_rx_frame_ctrl;

    localparam int NC = 1400;

    bit          clk = 1'b1;
    logic        rst;
    logic        rx_in;
    logic [5:0]  prescale;
    logic        par_en;
    logic        par_typ;
    logic [5:0]  edge_cnt = 6'd0;
    logic [3:0]  bit_cnt = 4'd0;
    logic        finish;
    logic        enable;
    logic [7:0]  p_data;
    logic        data_valid;
    logic        par_err;
    logic        stp_err;

    bit          line_q [NC];
    bit          rstl [NC];
    int          psl [NC];
    bit          pel [NC];
    bit          ptl [NC];
    bit          exp_en [NC];
    bit          exp_dv [NC];
    bit          exp_pe [NC];
    bit          exp_se [NC];
    bit [7:0]    exp_pd [NC];
    bit [11:0]   obs [NC];

    int          cur = 0;
    int          cfg_p = 16;
    bit          cfg_pe = 1'b0;
    bit          cfg_pt = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          win_lo [7];
    int          win_hi [7];
    int          rp;
    int          s4;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt), .finish(finish), .enable(enable),
        .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
        .stp_err(stp_err)
    );

    always #5 clk = ~clk;

    // Edge/bit counter partner: bit 0 period is one clock shorter than the rest
    assign finish = enable && (edge_cnt == ((bit_cnt == 4'd0) ? prescale - 6'd2 : prescale - 6'd1));

    always @(posedge clk) begin
        if (!enable) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else if (finish) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    task automatic put(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            line_q[cur] = v; rstl[cur] = 1'b1; psl[cur] = cfg_p;
            pel[cur] = cfg_pe; ptl[cur] = cfg_pt; cur++;
        end
    endtask

    task automatic add_frame(input bit [7:0] d, input int p, input bit pe, input bit pt,
                             input bit bad_par, input bit stop_v, input int flip);
        int s;
        bit pb;
        cfg_p = p; cfg_pe = pe; cfg_pt = pt; s = cur;
        put(1'b0, p);
        for (int j = 0; j < 8; j++) put(d[j], p);
        pb = ^d ^ pt;
        if (pe) put(bad_par ? ~pb : pb, p);
        put(stop_v, p);
        if (flip >= 0) line_q[s + (flip + 1) * p + p / 2] = ~line_q[s + (flip + 1) * p + p / 2];
    endtask

    // Bit value the receiver must see for frame bit j of a frame whose start edge is at cycle s
    function automatic bit sample_bit(input int s, input int j, input int p);
        int c;
        c = s + j * p + p / 2;
`ifdef RX_MAJORITY_EN
        return (int'(line_q[c - 1]) + int'(line_q[c]) + int'(line_q[c + 1])) >= 2;
`else
        return line_q[c];
`endif
    endfunction

    task automatic fill_pd(input int from, input bit [7:0] v);
        for (int i = from; i < NC; i++) exp_pd[i] = v;
    endtask

    // Frame-level model: decode each frame from the line, then place enable window and result pulse
    task automatic build_model();
        int t, s, p, m, nb, last_c, abort_c;
        bit pe, pt, ok_frame, pbit, sbit, perr;
        bit [7:0] d;
        for (int i = 0; i < NC; i++) begin
            exp_en[i] = 0; exp_dv[i] = 0; exp_pe[i] = 0; exp_se[i] = 0; exp_pd[i] = 8'h00;
        end
        t = 0;
        while (t < NC - 1) begin
            if (!rstl[t]) begin
                fill_pd(t + 1, 8'h00);
                t++;
            end else if (line_q[t]) begin
                t++;
            end else begin
                s = t; p = psl[s]; m = p / 2; pe = pel[s]; pt = ptl[s];
                ok_frame = !sample_bit(s, 0, p);
                d = 8'h00; perr = 1'b0; sbit = 1'b1;
                if (ok_frame) begin
                    for (int j = 0; j < 8; j++) d[j] = sample_bit(s, j + 1, p);
                    pbit = pe ? sample_bit(s, 9, p) : 1'b0;
                    perr = pe && (pbit != (^d ^ pt));
                    nb = pe ? 10 : 9;
                    sbit = sample_bit(s, nb, p);
                    last_c = s + nb * p + m + 2;
                end else begin
                    last_c = s + m + 2;
                end
                abort_c = -1;
                for (int r = s + 1; r <= last_c && abort_c < 0; r++) if (!rstl[r]) abort_c = r;
                if (abort_c >= 0) begin
                    for (int i = s + 1; i <= abort_c; i++) exp_en[i] = 1'b1;
                    t = abort_c;
                end else begin
                    for (int i = s + 1; i <= last_c; i++) exp_en[i] = 1'b1;
                    if (ok_frame) begin
                        exp_dv[last_c + 1] = !perr && sbit;
                        exp_pe[last_c + 1] = perr;
                        exp_se[last_c + 1] = !sbit;
                        if (!perr && sbit) fill_pd(last_c + 1, d);
                        t = last_c + 2;
                    end else begin
                        t = last_c + 1;
                    end
                end
            end
        end
    endtask

    function automatic int cnt(input int pos, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(obs[i][pos]);
        return n;
    endfunction

    task automatic lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            line_q[i] = 1'b1; rstl[i] = 1'b1; psl[i] = 16; pel[i] = 1'b0; ptl[i] = 1'b0;
        end
        cfg_p = 8;
        put(1'b1, 4);
        for (int i = 0; i < 4; i++) rstl[i] = 1'b0;
        put(1'b1, 10);
        win_lo[1] = cur; add_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1); put(1'b1, 20); win_hi[1] = cur - 1;
        win_lo[2] = cur; add_frame(8'h37, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1); put(1'b1, 20); win_hi[2] = cur - 1;
        win_lo[3] = cur; add_frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1); put(1'b1, 60); win_hi[3] = cur - 1;
        cfg_p = 16; cfg_pe = 1'b0;
        win_lo[4] = cur; s4 = cur; put(1'b0, 2); put(1'b1, 40); win_hi[4] = cur - 1;
        win_lo[5] = cur; add_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3); put(1'b1, 20); win_hi[5] = cur - 1;
        rp = cur + 3 * 16 + 5;
        add_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        for (int i = rp; i < cur; i++) line_q[i] = 1'b1;
        for (int i = rp; i < rp + 3; i++) rstl[i] = 1'b0;
        put(1'b1, 20);
        win_lo[6] = cur; add_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1); put(1'b1, 20); win_hi[6] = cur - 1;
        build_model();

        for (int t = 0; t < NC; t++) begin
            rx_in = line_q[t]; rst = rstl[t]; prescale = 6'(psl[t]);
            par_en = pel[t]; par_typ = ptl[t];
            @(negedge clk);
            obs[t] = {enable, data_valid, par_err, stp_err, p_data};
            if (t >= 1) begin
                checks++;
                if ({enable, data_valid, par_err, stp_err, p_data} !==
                    {exp_en[t], exp_dv[t], exp_pe[t], exp_se[t], exp_pd[t]}) begin
                    errors++;
                    $display("FAIL cycle %0d: dut en/dv/pe/se/pd=%b/%b/%b/%b/%h model=%b/%b/%b/%b/%h",
                             t, enable, data_valid, par_err, stp_err, p_data,
                             exp_en[t], exp_dv[t], exp_pe[t], exp_se[t], exp_pd[t]);
                end
            end
            @(posedge clk);
            #1;
        end

        lit("reset_state", int'(obs[2]), 0);
        lit("s1_valid", cnt(10, win_lo[1], win_hi[1]), 1);
        lit("s1_errors", cnt(9, win_lo[1], win_hi[1]) + cnt(8, win_lo[1], win_hi[1]), 0);
        lit("s1_pdata", int'(obs[win_hi[1]][7:0]), 'hA5);
        lit("s2_par_err", cnt(9, win_lo[2], win_hi[2]), 1);
        lit("s2_valid", cnt(10, win_lo[2], win_hi[2]), 0);
        lit("s2_pdata_kept", int'(obs[win_hi[2]][7:0]), 'hA5);
        lit("s3_stp_err", cnt(8, win_lo[3], win_hi[3]), 1);
        lit("s3_valid", cnt(10, win_lo[3], win_hi[3]), 0);
        lit("s4_enable_start", int'(obs[s4 + 1][11]), 1);
        lit("s4_pulses", cnt(10, win_lo[4], win_hi[4]) + cnt(9, win_lo[4], win_hi[4]) + cnt(8, win_lo[4], win_hi[4]), 0);
        lit("s4_enable_end", int'(obs[win_hi[4]][11]), 0);
        lit("s5_valid", cnt(10, win_lo[5], win_hi[5]), 1);
`ifdef RX_MAJORITY_EN
        lit("s5_pdata", int'(obs[win_hi[5]][7:0]), 'hC3);
`else
        lit("s5_pdata", int'(obs[win_hi[5]][7:0]), 'hCB);
`endif
        lit("s6_enable_before_reset", int'(obs[rp][11]), 1);
        lit("s6_outputs_after_reset", int'(obs[rp + 1]), 0);
        lit("s6_valid", cnt(10, win_lo[6], win_hi[6]), 1);
        lit("s6_pdata", int'(obs[win_hi[6]][7:0]), 'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
